// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_pkg
// Purpose  : Shared UART types and bit-timing constants (TX and RX)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } tx_state_t;

    localparam int BAUD_DIV_DEFAULT  = 2604;
    localparam int BAUD_HALF_DEFAULT = BAUD_DIV_DEFAULT / 2;
    localparam int FRAME_BITS        = 10;
    localparam int DATA_BITS         = 8;
    localparam int BAUD_CNT_W        = 12;
    localparam int BIT_CNT_W         = 4;

    // Start bit sits in bit 0 so the line is simply shift_reg[0].
    function automatic logic [DATA_BITS:0] frame_load(input logic [DATA_BITS-1:0] data);
        return {data, 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_if
// Purpose  : Byte-strobe request and serial/status signals of the UART TX
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_tx_if;
    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       tx_busy;
    logic       hold_full;
    logic       tx_done;

    modport master (
        output trmt, tx_data,
        input  TX, tx_busy, hold_full, tx_done
    );

    modport slave (
        input  trmt, tx_data,
        output TX, tx_busy, hold_full, tx_done
    );
endinterface

`default_nettype wire

// File: rtl/uart_baud_tmr.sv
//------------------------------------------------------------------------------
// Module   : uart_baud_tmr
// Purpose  : Clearable 12-bit bit-period counter, ticks at a compare value
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_baud_tmr
    import uart_pkg::*;
#(
    parameter int TICK_AT = BAUD_DIV_DEFAULT - 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic run,
    input  wire logic clr,
    output logic      tick
);

    logic [BAUD_CNT_W-1:0] cnt_q;
    logic [BAUD_CNT_W-1:0] cnt_d;

    assign tick = run && (cnt_q == BAUD_CNT_W'(TICK_AT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
//------------------------------------------------------------------------------
// Module   : uart_tx
// Purpose  : 8N1 UART transmitter with a one-byte holding register
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst_n,
    uart_tx_if.slave  bus
);

    tx_state_t                state_q, state_d;
    logic [DATA_BITS:0]       shift_q, shift_d;
    logic [DATA_BITS-1:0]     hold_q, hold_d;
    logic                     hold_full_q, hold_full_d;
    logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                     tx_done_q, tx_done_d;
    logic                     cnt_clr;
    logic                     tick;
    logic                     frame_end;

    uart_baud_tmr #(
        .TICK_AT (BAUD_DIV - 1)
    ) u_baud_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_q == TRANSMIT),
        .clr   (cnt_clr),
        .tick  (tick)
    );

    assign frame_end = tick && (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        tx_done_d   = tx_done_q;
        cnt_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.trmt) begin
                    shift_d   = frame_load(bus.tx_data);
                    bit_cnt_d = '0;
                    cnt_clr   = 1'b1;
                    tx_done_d = 1'b0;
                    state_d   = TRANSMIT;
                end
            end
            TRANSMIT: begin
                if (tick) begin
                    shift_d   = {1'b1, shift_q[DATA_BITS:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                // A queued byte wins over a new strobe landing on the frame end.
                if (frame_end) begin
                    bit_cnt_d = '0;
                    cnt_clr   = 1'b1;
                    if (hold_full_q) begin
                        shift_d     = frame_load(hold_q);
                        hold_full_d = 1'b0;
                    end else if (bus.trmt) begin
                        shift_d   = frame_load(bus.tx_data);
                        tx_done_d = 1'b0;
                    end else begin
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end
                end else if (bus.trmt && !hold_full_q) begin
                    hold_d      = bus.tx_data;
                    hold_full_d = 1'b1;
                    tx_done_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign bus.TX        = (state_q == TRANSMIT) ? shift_q[0] : 1'b1;
    assign bus.tx_busy   = (state_q == TRANSMIT);
    assign bus.hold_full = hold_full_q;
    assign bus.tx_done   = tx_done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_tx
// Purpose  : Directed self-checking bench for uart_tx (BAUD_DIV 16 and 2604)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx;

    localparam int BD      = 16;
    localparam int FRAME   = 10 * BD;
    localparam int BD_LONG = 2604;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // line[i] is the i-th bit on the wire
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_tx_if bus ();
    uart_tx_if bus_l ();

    uart_tx #(.BAUD_DIV(BD)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    uart_tx #(.BAUD_DIV(BD_LONG)) u_dut_long (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        bus.trmt    = 1'b1;
        bus.tx_data = d;
        step();
        bus.trmt    = 1'b0;
    endtask

    // Walks one 160-cycle frame starting just after the edge that started it.
    task automatic run_frame(input string nm, input logic [9:0] line,
                             input int inj1, input logic [7:0] d1,
                             input int inj2, input logic [7:0] d2,
                             input int hold_from);
        int         width_err = 0;
        int         busy_err  = 0;
        int         done_err  = 0;
        int         hold_err  = 0;
        logic [9:0] mid       = '0;
        for (int j = 0; j < FRAME; j++) begin
            if (bus.TX !== line[j / BD]) width_err++;
            if (j % BD == BD / 2) mid[j / BD] = bus.TX;
            if (bus.tx_busy !== 1'b1) busy_err++;
            if (bus.tx_done !== 1'b0) done_err++;
            if (bus.hold_full !== (j >= hold_from)) hold_err++;
            bus.trmt    = (j == inj1) || (j == inj2);
            bus.tx_data = (j == inj2) ? d2 : d1;
            step();
        end
        bus.trmt = 1'b0;
        chk({nm, "_bits"},      32'(mid),      32'(line));
        chk({nm, "_width_err"}, width_err,     0);
        chk({nm, "_busy_err"},  busy_err,      0);
        chk({nm, "_done_err"},  done_err,      0);
        chk({nm, "_hold_err"},  hold_err,      0);
    endtask

    task automatic check_idle(input string nm, input logic done_exp);
        chk({nm, "_TX"},        32'(bus.TX),        1);
        chk({nm, "_tx_busy"},   32'(bus.tx_busy),   0);
        chk({nm, "_hold_full"}, 32'(bus.hold_full), 0);
        chk({nm, "_tx_done"},   32'(bus.tx_done),   32'(done_exp));
    endtask

    vec_t tbl [5];

    initial begin
        bus.trmt      = 1'b0;
        bus.tx_data   = '0;
        bus_l.trmt    = 1'b0;
        bus_l.tx_data = '0;
        rst_n         = 1'b0;

        tbl[0] = '{8'hA5, 10'b1_10100101_0};
        tbl[1] = '{8'h00, 10'b1_00000000_0};
        tbl[2] = '{8'hFF, 10'b1_11111111_0};
        tbl[3] = '{8'h3C, 10'b1_00111100_0};
        tbl[4] = '{8'h81, 10'b1_10000001_0};

        repeat (3) step();
        check_idle("reset", 1'b0);
        rst_n = 1'b1;
        repeat (2) step();

        // Single frames, each followed by an idle gap to check stickiness of tx_done
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].data);
            run_frame($sformatf("single_%02h", tbl[i].data), tbl[i].line, -1, 8'h00, -1, 8'h00, FRAME);
            check_idle($sformatf("single_%02h_end", tbl[i].data), 1'b1);
            repeat (3) step();
            check_idle($sformatf("single_%02h_sticky", tbl[i].data), 1'b1);
        end

        // Back-to-back via holding register; 8'h11 arrives while full and is dropped
        send(8'h55);
        run_frame("b2b_55", 10'b1_01010101_0, 40, 8'hF0, 60, 8'h11, 41);
        run_frame("b2b_F0", 10'b1_11110000_0, -1, 8'h00, -1, 8'h00, FRAME);
        check_idle("b2b_end", 1'b1);
        begin
            int busy_seen = 0;
            for (int j = 0; j < 2 * FRAME; j++) begin
                if (bus.tx_busy !== 1'b0 || bus.TX !== 1'b1) busy_seen++;
                step();
            end
            chk("dropped_byte_activity", busy_seen, 0);
        end

        // Strobe exactly on the frame-end edge restarts without an idle bit
        send(8'h3C);
        run_frame("fe_3C", 10'b1_00111100_0, FRAME - 1, 8'h81, -1, 8'h00, FRAME);
        run_frame("fe_81", 10'b1_10000001_0, -1, 8'h00, -1, 8'h00, FRAME);
        check_idle("fe_end", 1'b1);

        // Asynchronous reset at cycle 70 of a frame with a byte queued
        send(8'hA5);
        for (int j = 0; j < 70; j++) begin
            bus.trmt    = (j == 10);
            bus.tx_data = 8'hF0;
            step();
        end
        bus.trmt = 1'b0;
        chk("pre_rst_hold_full", 32'(bus.hold_full), 1);
        chk("pre_rst_busy",      32'(bus.tx_busy),   1);
        #3 rst_n = 1'b0;
        #1;
        check_idle("rst_mid", 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check_idle("rst_release", 1'b0);
        send(8'h81);
        run_frame("post_rst_81", 10'b1_10000001_0, -1, 8'h00, -1, 8'h00, FRAME);
        check_idle("post_rst_end", 1'b1);

        // Full-rate frame decoded at the receiver's mid-bit sample point
        begin
            int         n;
            logic [9:0] rx = '0;
            bus_l.trmt    = 1'b1;
            bus_l.tx_data = 8'h3C;
            step();
            bus_l.trmt = 1'b0;
            for (n = 0; n < 27000; n++) begin
                if (bus_l.tx_done) break;
                if (n % BD_LONG == BD_LONG / 2 && n / BD_LONG < 10) rx[n / BD_LONG] = bus_l.TX;
                step();
            end
            chk("long_done_latency", n, 26040);
            chk("long_start_bit",    32'(rx[0]),   0);
            chk("long_rx_data",      32'(rx[8:1]), 32'h3C);
            chk("long_stop_bit",     32'(rx[9]),   1);
            chk("long_idle_TX",      32'(bus_l.TX), 1);
            chk("long_idle_busy",    32'(bus_l.tx_busy), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
